// File: rtl/contador_pkg.sv
// Shared types and defaults for the bounded oscillating counter family.
// The optional CONTADOR_STEP_EN macro adds a programmable step port (see contador_oscilante_param.sv).
package contador_pkg;

  localparam int NBITS_DEFAULT = 8;

  typedef enum logic [1:0] {
    WRAP     = 2'b00,
    SAT      = 2'b01,
    PINGPONG = 2'b10,
    HOLD     = 2'b11
  } mode_e;

endpackage

// File: rtl/contador_oscilante_param_if.sv
// Control/status bundle for contador_oscilante_param.
// The step signal exists only when CONTADOR_STEP_EN is defined.
interface contador_oscilante_param_if
  import contador_pkg::*;
#(
  parameter int NBITS = NBITS_DEFAULT
);

  logic             load;
  logic [NBITS-1:0] data_in;
  logic             counter_on;
  logic             count_up;
  mode_e            mode;
  logic [NBITS-1:0] lo_bound;
  logic [NBITS-1:0] hi_bound;
`ifdef CONTADOR_STEP_EN
  logic [NBITS-1:0] step;
`endif
  logic [NBITS-1:0] count;
  logic             dir;
  logic             tc;
  logic             bound_err;

`ifdef CONTADOR_STEP_EN
  modport master (
    output load, data_in, counter_on, count_up, mode, lo_bound, hi_bound, step,
    input  count, dir, tc, bound_err
  );
  modport slave (
    input  load, data_in, counter_on, count_up, mode, lo_bound, hi_bound, step,
    output count, dir, tc, bound_err
  );
`else
  modport master (
    output load, data_in, counter_on, count_up, mode, lo_bound, hi_bound,
    input  count, dir, tc, bound_err
  );
  modport slave (
    input  load, data_in, counter_on, count_up, mode, lo_bound, hi_bound,
    output count, dir, tc, bound_err
  );
`endif

endinterface

// File: rtl/contador_step_calc.sv
// Combinational next-state for one counting step: bound checks are done one bit
// wider than the count so that count+step and lo+step can never overflow.
module contador_step_calc
  import contador_pkg::*;
#(
  parameter int NBITS = NBITS_DEFAULT
) (
  input  logic [NBITS-1:0] i_count,
  input  logic [NBITS-1:0] i_step,
  input  logic [NBITS-1:0] i_lo,
  input  logic [NBITS-1:0] i_hi,
  input  mode_e            i_mode,
  input  logic             i_dir,
  output logic [NBITS-1:0] o_next_count,
  output logic             o_next_dir,
  output logic             o_hit_bound
);

  localparam int W = NBITS + 1;

  logic [W-1:0] w_c, w_hi, w_up, w_lo_s;

  assign w_c    = {1'b0, i_count};
  assign w_hi   = {1'b0, i_hi};
  assign w_up   = w_c + {1'b0, i_step};
  assign w_lo_s = {1'b0, i_lo} + {1'b0, i_step};

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    o_next_count = i_count;
    o_next_dir   = i_dir;
    o_hit_bound  = 1'b0;
    case (i_mode)
      WRAP: begin
        if (i_dir) begin
          if (w_up > w_hi) begin
            o_next_count = i_lo;
            o_hit_bound  = 1'b1;
          end else o_next_count = w_up[NBITS-1:0];
        end else begin
          if (w_c < w_lo_s) begin
            o_next_count = i_hi;
            o_hit_bound  = 1'b1;
          end else o_next_count = i_count - i_step;
        end
      end
      SAT: begin
        // Sitting on the bound already: clamp again but stay silent.
        if (i_dir) begin
          if (w_up >= w_hi) begin
            o_next_count = i_hi;
            o_hit_bound  = (i_count != i_hi);
          end else o_next_count = w_up[NBITS-1:0];
        end else begin
          if (w_c <= w_lo_s) begin
            o_next_count = i_lo;
            o_hit_bound  = (i_count != i_lo);
          end else o_next_count = i_count - i_step;
        end
      end
      PINGPONG: begin
        if (i_dir) begin
          if (w_up >= w_hi) begin
            o_next_count = i_hi;
            o_next_dir   = 1'b0;
            o_hit_bound  = 1'b1;
          end else o_next_count = w_up[NBITS-1:0];
        end else begin
          if (w_c <= w_lo_s) begin
            o_next_count = i_lo;
            o_next_dir   = 1'b1;
            o_hit_bound  = 1'b1;
          end else o_next_count = i_count - i_step;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/contador_oscilante_param.sv
// Bounded up/down counter with WRAP, SAT, PINGPONG and HOLD modes, parallel load
// and a one-cycle terminal-count pulse. Define CONTADOR_STEP_EN for a programmable step.
module contador_oscilante_param
  import contador_pkg::*;
#(
  parameter int NBITS = NBITS_DEFAULT
) (
  input logic                       clk,
  input logic                       reset,
  contador_oscilante_param_if.slave bus
);

  logic [NBITS-1:0] r_count;
  logic             r_dir;
  logic             r_tc;
  logic             r_bound_err;

  logic [NBITS-1:0] w_s;
  logic [NBITS-1:0] w_next_count;
  logic             w_next_dir;
  logic             w_hit_bound;
  logic             w_dir_eff;
  logic             w_step_ok;

`ifdef CONTADOR_STEP_EN
  assign w_s = bus.step;
`else
  assign w_s = NBITS'(1);
`endif

  // Outside PINGPONG the direction input acts immediately; in PINGPONG the register steers.
  assign w_dir_eff = (bus.mode == PINGPONG) ? r_dir : bus.count_up;
  assign w_step_ok = bus.counter_on && (bus.mode != HOLD) && !r_bound_err && (w_s != '0);

  contador_step_calc #(.NBITS(NBITS)) u_step_calc (
    .i_count      (r_count),
    .i_step       (w_s),
    .i_lo         (bus.lo_bound),
    .i_hi         (bus.hi_bound),
    .i_mode       (bus.mode),
    .i_dir        (w_dir_eff),
    .o_next_count (w_next_count),
    .o_next_dir   (w_next_dir),
    .o_hit_bound  (w_hit_bound)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count     <= '0;
      r_dir       <= 1'b1;
      r_tc        <= 1'b0;
      r_bound_err <= 1'b0;
    end else begin
      r_bound_err <= (bus.lo_bound > bus.hi_bound);
      r_tc        <= 1'b0;
      if (bus.load) begin
        r_count <= bus.data_in;
        r_dir   <= bus.count_up;
      end else begin
        if (bus.mode != PINGPONG) r_dir <= bus.count_up;
        if (w_step_ok) begin
          r_count <= w_next_count;
          r_tc    <= w_hit_bound;
          if (bus.mode == PINGPONG) r_dir <= w_next_dir;
        end
      end
    end
  end

  assign bus.count     = r_count;
  assign bus.dir       = r_dir;
  assign bus.tc        = r_tc;
  assign bus.bound_err = r_bound_err;

endmodule

// File: tb/tb_contador_oscilante_param.sv
// Directed bench for contador_oscilante_param; step-size vectors run only with CONTADOR_STEP_EN.
module tb_contador_oscilante_param;
  import contador_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  contador_oscilante_param_if #(.NBITS(8)) bus ();

  contador_oscilante_param #(.NBITS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int wrap_cnt [4] = '{1, 2, 3, 0};
  int wrap_tc  [4] = '{0, 0, 0, 1};
  int pp_cnt   [7] = '{1, 2, 3, 2, 1, 0, 1};
  int pp_tc    [7] = '{0, 0, 1, 0, 0, 1, 0};
  int pp_dir   [7] = '{1, 1, 0, 0, 0, 1, 1};
  int sat_cnt  [4] = '{3, 2, 2, 2};
  int sat_tc   [4] = '{0, 1, 0, 0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset          = 1'b0;
    bus.load       = 1'b0;
    bus.data_in    = '0;
    bus.counter_on = 1'b0;
    bus.count_up   = 1'b1;
    bus.mode       = WRAP;
    bus.lo_bound   = 8'd0;
    bus.hi_bound   = 8'd3;
`ifdef CONTADOR_STEP_EN
    bus.step       = 8'd1;
`endif
    #12;
    check("rst_count", 32'(bus.count), 0);
    check("rst_dir", 32'(bus.dir), 1);
    check("rst_tc", 32'(bus.tc), 0);
    check("rst_berr", 32'(bus.bound_err), 0);

    // Load 5 going down, then reset asynchronously mid-cycle.
    reset = 1'b1;
    bus.data_in = 8'd5; bus.count_up = 1'b0; bus.load = 1'b1;
    tick();
    check("load5_count", 32'(bus.count), 5);
    check("load5_dir", 32'(bus.dir), 0);
    bus.load = 1'b0;
    tick();
    check("idle_count", 32'(bus.count), 5);
    reset = 1'b0;
    #2;
    check("async_count", 32'(bus.count), 0);
    check("async_dir", 32'(bus.dir), 1);
    check("async_tc", 32'(bus.tc), 0);
    reset = 1'b1;

    // WRAP 0..3 up
    bus.count_up = 1'b1; bus.counter_on = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("wrap_count%0d", i), 32'(bus.count), 32'(wrap_cnt[i]));
      check($sformatf("wrap_tc%0d", i), 32'(bus.tc), 32'(wrap_tc[i]));
    end

    // PINGPONG 0..3, count_up ignored after load
    bus.counter_on = 1'b0; bus.mode = PINGPONG; bus.data_in = 8'd0; bus.load = 1'b1;
    tick();
    check("pp_load_count", 32'(bus.count), 0);
    check("pp_load_dir", 32'(bus.dir), 1);
    bus.load = 1'b0; bus.counter_on = 1'b1; bus.count_up = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      check($sformatf("pp_count%0d", i), 32'(bus.count), 32'(pp_cnt[i]));
      check($sformatf("pp_tc%0d", i), 32'(bus.tc), 32'(pp_tc[i]));
      check($sformatf("pp_dir%0d", i), 32'(bus.dir), 32'(pp_dir[i]));
    end

    // SAT down lo=2 hi=9 from 4, load alongside counter_on
    bus.mode = SAT; bus.lo_bound = 8'd2; bus.hi_bound = 8'd9;
    bus.data_in = 8'd4; bus.load = 1'b1;
    tick();
    check("sat_load_count", 32'(bus.count), 4);
    check("sat_load_tc", 32'(bus.tc), 0);
    bus.load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("sat_count%0d", i), 32'(bus.count), 32'(sat_cnt[i]));
      check($sformatf("sat_tc%0d", i), 32'(bus.tc), 32'(sat_tc[i]));
    end
    check("sat_dir", 32'(bus.dir), 0);

    // HOLD freezes count, dir still follows count_up
    bus.mode = HOLD; bus.count_up = 1'b1;
    tick();
    check("hold_count", 32'(bus.count), 2);
    check("hold_tc", 32'(bus.tc), 0);
    check("hold_dir", 32'(bus.dir), 1);

    // Out-of-range load with load priority over step
    bus.mode = WRAP; bus.lo_bound = 8'd10; bus.hi_bound = 8'd20;
    bus.data_in = 8'd200; bus.load = 1'b1;
    tick();
    check("oor_load_count", 32'(bus.count), 200);
    check("oor_load_tc", 32'(bus.tc), 0);
    bus.load = 1'b0;
    tick();
    check("oor_wrap_count", 32'(bus.count), 10);
    check("oor_wrap_tc", 32'(bus.tc), 1);
    tick();
    check("oor_next_count", 32'(bus.count), 11);
    check("oor_next_tc", 32'(bus.tc), 0);

    // Inverted bounds
    bus.counter_on = 1'b0; bus.lo_bound = 8'd7; bus.hi_bound = 8'd3;
    tick();
    check("berr_set", 32'(bus.bound_err), 1);
    check("berr_count0", 32'(bus.count), 11);
    bus.counter_on = 1'b1;
    tick();
    check("berr_frozen", 32'(bus.count), 11);
    check("berr_tc", 32'(bus.tc), 0);
    bus.data_in = 8'd5; bus.load = 1'b1;
    tick();
    check("berr_load", 32'(bus.count), 5);
    bus.load = 1'b0;
    tick();
    check("berr_still", 32'(bus.count), 5);
    bus.lo_bound = 8'd2;
    tick();
    check("berr_clear", 32'(bus.bound_err), 0);
    check("berr_clear_count", 32'(bus.count), 5);
    tick();
    check("resume_count0", 32'(bus.count), 2);
    check("resume_tc0", 32'(bus.tc), 1);
    tick();
    check("resume_count1", 32'(bus.count), 3);
    check("resume_tc1", 32'(bus.tc), 0);
    tick();
    check("resume_count2", 32'(bus.count), 2);
    check("resume_tc2", 32'(bus.tc), 1);

`ifdef CONTADOR_STEP_EN
    bus.step = 8'd3; bus.lo_bound = 8'd0; bus.hi_bound = 8'd10;
    bus.data_in = 8'd9; bus.load = 1'b1;
    tick();
    check("s3_load", 32'(bus.count), 9);
    bus.load = 1'b0;
    tick();
    check("s3_wrap_count", 32'(bus.count), 0);
    check("s3_wrap_tc", 32'(bus.tc), 1);
    bus.mode = PINGPONG; bus.data_in = 8'd8; bus.load = 1'b1;
    tick();
    check("s3_pp_load", 32'(bus.count), 8);
    bus.load = 1'b0;
    tick();
    check("s3_pp_count0", 32'(bus.count), 10);
    check("s3_pp_tc0", 32'(bus.tc), 1);
    check("s3_pp_dir0", 32'(bus.dir), 0);
    tick();
    check("s3_pp_count1", 32'(bus.count), 7);
    check("s3_pp_tc1", 32'(bus.tc), 0);
    bus.step = 8'd0;
    tick();
    check("s0_freeze", 32'(bus.count), 7);
    check("s0_tc", 32'(bus.tc), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/contador_oscilante_param.md
# contador_oscilante_param

Parametrised up/down counter with programmable lower and upper bounds and three counting modes: wrap, saturate, and ping-pong. In ping-pong mode the counter reverses direction automatically at each bound. It emits a one-cycle terminal-count pulse on every bound event and supports parallel load. It is the general-purpose successor to the fixed 2-bit oscillating counter and is used wherever the datapath needs a bounded sweep or index generator.

## Interface
- `NBITS`, 8, counter width; must be ≥ 2.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `load` in 1: synchronous parallel load.
- `data_in` in NBITS: load value.
- `counter_on` in 1: step enable.
- `count_up` in 1: direction (1 = up). In ping-pong mode it is the start direction and is sampled only on `load`.
- `mode` in 2: `contador_pkg::mode_e`. Encoding: 00 WRAP, 01 SAT, 10 PINGPONG, 11 HOLD.
- `lo_bound` in NBITS: inclusive lower bound, unsigned.
- `hi_bound` in NBITS: inclusive upper bound, unsigned.
- `step` in NBITS: step size. Present only with `CONTADOR_STEP_EN`.
- `count` out NBITS: current count.
- `dir` out 1: current direction register (1 = up).
- `tc` out 1: terminal-count pulse.
- `bound_err` out 1: registered flag, high when `lo_bound > hi_bound`.

## Operation
- Priority: reset > load > step.
- **Load**
  - `count <= data_in`, with no clamping.
  - `dir <= count_up`; `tc <= 0`.
- **Step** occurs when `counter_on`=1, `mode`≠HOLD, `bound_err`=0, and S≠0.
  - S = `step` (macro on) or 1 (macro off).
  - All sums and differences are computed in NBITS+1 bits, so there is no silent overflow.
- **WRAP**
  - Up: if count+S > hi, then count←lo and tc←1; otherwise count←count+S.
  - Down: if count < lo+S, then count←hi and tc←1; otherwise count←count−S.
- **SAT**
  - Up: if count+S ≥ hi, then count←hi, and tc←1 only if count≠hi beforehand.
  - Down: mirror of up, clamping to lo.
  - Holding at a bound never re-pulses `tc`.
- **PINGPONG**
  - Up: if count+S ≥ hi, then count←hi, dir←0, tc←1; otherwise count←count+S.
  - Down: if count < lo+S or count−S = lo, then count←lo, dir←1, tc←1.
  - Reaching a bound exactly also reverses direction.
- **Direction register**
  - In non-PINGPONG modes, `dir <= count_up` every cycle, regardless of `counter_on`.
  - In PINGPONG, `dir` changes only on load or on a bounce.
  - Entering PINGPONG continues in the current `dir`.
- **Out-of-range count** (after a load outside [lo, hi]): the rules above apply unchanged. The next step therefore moves the count to the appropriate bound or wraps it.
- **HOLD, S=0, `counter_on`=0, or `bound_err`=1**: `count` holds and `tc` is 0. Load still works.
- **Bound changes mid-count** take effect on the next step. No other state is affected.

## Timing
- All outputs are registered. Latency from an input to `count`/`dir`/`tc` is 1 clock.
- `tc` is high for exactly the one cycle in which `count` shows the bound or wrap value.
- `bound_err` reflects the bounds sampled on the previous clock edge.
- **Reset** (asynchronous assert, synchronous release by the system): count=0, dir=1, tc=0, bound_err=0.
- Reset asserted mid-operation clears all state immediately. There is no pending event after release.
- `load` together with `counter_on`: load wins and no step is taken that cycle.

## Configuration
- `CONTADOR_STEP_EN`
  - Defined: the `step` port exists and the step magnitude equals `step`; `step`=0 freezes counting.
  - Undefined: there is no `step` port and the step magnitude is fixed at 1.
  - All other behaviour is identical in both builds.

## Structure
- Package `contador_pkg`:
  - `mode_e` enum (WRAP, SAT, PINGPONG, HOLD).
  - `NBITS_DEFAULT` = 8.
- Sub-module `contador_step_calc`:
  - Purely combinational.
  - Inputs: count, S, lo, hi, mode, dir.
  - Outputs: next_count, next_dir, hit_bound.
- The top module holds the registers, the load/enable priority, and `bound_err`.

## Test plan
- Reset low with count=5 → count=0, dir=1, tc=0 immediately. After release with WRAP, lo=0, hi=3, counting up: count 1,2,3,0, with tc only on the 0.
- PINGPONG, lo=0, hi=3, S=1, start 0 up → 1,2,3,2,1,0,1, with tc and a dir flip at each 3 and each 0.
- SAT, down, lo=2, hi=9, load 4 → 3,2,2,2, with a single tc on the first 2.
- Step on: WRAP, up, S=3, lo=0, hi=10, load 9 → next 0 with tc. PINGPONG, S=3, load 8 → 10 (tc, dir=0), then 7.
- Load 200 with lo=10, hi=20, WRAP, up → next 10 with tc. The same cycle with load=1 and counter_on=1 shows load priority.
- lo=7, hi=3 → bound_err=1 next cycle and count frozen. Load 5 → count=5. Restoring lo=2 → bound_err=0 and counting resumes.
